otter_csr: RTL and testbench

OTTER_CSR -- requirements
Module: otter_csr

---
 rtl/otter_csr_pkg.sv | 34 +++
 rtl/otter_csr_if.sv | 30 +++
 rtl/otter_csr_intr_sync.sv | 28 ++
 rtl/otter_csr.sv | 125 ++++++++++++
 tb/tb_otter_csr.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/otter_csr_pkg.sv
// Shared CSR addresses, operation encoding and trap constants for the OTTER machine-mode CSR file.
// Also holds the read-modify-write helper used by CSR instructions.
package otter_csr_pkg;

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [31:0] MCAUSE_EXT_INT = 32'h8000_000B;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIP_MEIP     = 11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val, logic [31:0] wd);
    case (op)
      CSR_OP_RW: return wd;
      CSR_OP_RS: return old_val | wd;
      CSR_OP_RC: return old_val & ~wd;
      default:   return old_val;
    endcase
  endfunction

endpackage

// File: rtl/otter_csr_if.sv
// CSR access, trap control and interrupt signals between the OTTER core and its CSR file.
// master = core side, slave = CSR file.
interface otter_csr_if;
  import otter_csr_pkg::*;

  logic [11:0] csr_ADDR;
  csr_op_e     csr_op;
  logic        csr_WE;
  logic [31:0] csr_WD;
  logic [31:0] PC;
  logic        int_taken;
  logic        mret_exec;
  logic        INTR;
  logic [31:0] csr_RD;
  logic        csr_illegal;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        intr_req;

  modport master (
    output csr_ADDR, csr_op, csr_WE, csr_WD, PC, int_taken, mret_exec, INTR,
    input  csr_RD, csr_illegal, mtvec, mepc, intr_req
  );

  modport slave (
    input  csr_ADDR, csr_op, csr_WE, csr_WD, PC, int_taken, mret_exec, INTR,
    output csr_RD, csr_illegal, mtvec, mepc, intr_req
  );

endinterface

// File: rtl/otter_csr_intr_sync.sv
// Two-flop synchronizer for the async INTR level plus rising-edge detect; registered one-cycle pulse,
// so an INTR rise sampled at edge N shows up as rise_pulse after edge N+2. No backpressure.
module intr_sync (
  input  logic CLK,
  input  logic RST,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync1;
  logic sync2;
  logic sync3;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync1      <= async_in;
      sync2      <= sync1;
      sync3      <= sync2;
      rise_pulse <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/otter_csr.sv
// Machine-mode CSR file: combinational read, single-cycle RW/RS/RC writes, trap entry/return and
// external interrupt pending logic. Zero-latency read, one-edge update; no backpressure.
module otter_csr
  import otter_csr_pkg::*;
(
  input logic        CLK,
  input logic        RST,
  otter_csr_if.slave bus
);

  logic        mie;
  logic        mpie;
  logic        pending;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch_q;
  logic [31:0] mepc_q;
  logic [31:0] mcause_q;

  logic        intr_rise;
  logic        mapped;
  logic [31:0] rd_val;
  logic [31:0] wr_val;
  logic        wr_en;
  logic        wr_mstatus;
  logic        wr_mtvec;
  logic        wr_mscratch;
  logic        wr_mepc;
  logic        wr_mcause;

  intr_sync u_intr_sync (
    .CLK        (CLK),
    .RST        (RST),
    .async_in   (bus.INTR),
    .rise_pulse (intr_rise)
  );

  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (bus.csr_ADDR)
      CSR_MSTATUS: begin
        rd_val[MSTATUS_MIE]  = mie;
        rd_val[MSTATUS_MPIE] = mpie;
      end
      CSR_MTVEC:    rd_val = mtvec_q;
      CSR_MSCRATCH: rd_val = mscratch_q;
      CSR_MEPC:     rd_val = mepc_q;
      CSR_MCAUSE:   rd_val = mcause_q;
      CSR_MIP:      rd_val[MIP_MEIP] = pending;
      default:      mapped = 1'b0;
    endcase
  end

  // mip is read-only, so it is excluded from every write strobe
  always_comb begin
    wr_val      = csr_apply(bus.csr_op, rd_val, bus.csr_WD);
    wr_en       = bus.csr_WE && (bus.csr_op != CSR_OP_NONE) && mapped;
    wr_mstatus  = wr_en && (bus.csr_ADDR == CSR_MSTATUS);
    wr_mtvec    = wr_en && (bus.csr_ADDR == CSR_MTVEC);
    wr_mscratch = wr_en && (bus.csr_ADDR == CSR_MSCRATCH);
    wr_mepc     = wr_en && (bus.csr_ADDR == CSR_MEPC);
    wr_mcause   = wr_en && (bus.csr_ADDR == CSR_MCAUSE);
  end

  // Trap entry owns MIE/MPIE/mepc/mcause; MRET owns MIE/MPIE; plain writes get what is left.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mepc_q   <= '0;
      mcause_q <= '0;
    end else if (bus.int_taken) begin
      mepc_q   <= bus.PC & ~32'd3;
      mcause_q <= MCAUSE_EXT_INT;
      mpie     <= mie;
      mie      <= 1'b0;
    end else begin
      if (bus.mret_exec) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (wr_mstatus) begin
        mie  <= wr_val[MSTATUS_MIE];
        mpie <= wr_val[MSTATUS_MPIE];
      end
      if (wr_mepc) begin
        mepc_q <= wr_val & ~32'd3;
      end
      if (wr_mcause) begin
        mcause_q <= wr_val;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mtvec_q    <= '0;
      mscratch_q <= '0;
    end else begin
      if (wr_mtvec) begin
        mtvec_q <= wr_val & ~32'd3;
      end
      if (wr_mscratch) begin
        mscratch_q <= wr_val;
      end
    end
  end

  // A fresh edge beats the clear from a coincident trap so that interrupt is not lost
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pending <= 1'b0;
    end else if (intr_rise) begin
      pending <= 1'b1;
    end else if (bus.int_taken) begin
      pending <= 1'b0;
    end
  end

  assign bus.csr_RD      = rd_val;
  assign bus.csr_illegal = ~mapped;
  assign bus.mtvec       = mtvec_q;
  assign bus.mepc        = mepc_q;
  assign bus.intr_req    = pending & mie;

endmodule

// File: tb/tb_otter_csr.sv
// Directed and randomized checks of otter_csr against an address-keyed reference model.
module tb_otter_csr;
  import otter_csr_pkg::*;

  logic CLK;
  logic RST;
  otter_csr_if bus();

  otter_csr dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  bit [31:0] csrs  [int];
  bit [31:0] wmask [int];
  bit        intr_hist [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic ref_reset();
    foreach (wmask[a]) csrs[a] = 32'h0;
    intr_hist.delete();
  endtask

  // Reference: apply plain write, then MRET, then trap, then new interrupt edge; later steps override earlier.
  task automatic ref_update();
    bit [31:0] old [int];
    bit [31:0] v;
    bit [31:0] m;
    int a;
    int n;
    bit edge_now;
    old = csrs;
    a = int'(bus.csr_ADDR);
    if (bus.csr_WE && int'(bus.csr_op) != 0 && old.exists(a)) begin
      case (int'(bus.csr_op))
        1: v = bus.csr_WD;
        2: v = old[a] | bus.csr_WD;
        default: v = old[a] & ~bus.csr_WD;
      endcase
      csrs[a] = (v & wmask[a]) | (old[a] & ~wmask[a]);
    end
    m = old['h300];
    if (bus.mret_exec) csrs['h300] = 32'h80 | ((m >> 4) & 32'h8);
    if (bus.int_taken) begin
      csrs['h341] = bus.PC & ~32'd3;
      csrs['h342] = 32'h8000_000B;
      csrs['h300] = (m & 32'h8) << 4;
      csrs['h344] = 32'h0;
    end
    intr_hist.push_back(bus.INTR);
    n = intr_hist.size();
    edge_now = (n >= 4) && intr_hist[n-4] && ((n < 5) || !intr_hist[n-5]);
    if (edge_now) csrs['h344] = 32'h800;
  endtask

  task automatic check_outputs(input string tag);
    int a;
    bit [31:0] exp_rd;
    bit exp_req;
    a = int'(bus.csr_ADDR);
    exp_rd = csrs.exists(a) ? csrs[a] : 32'h0;
    exp_req = csrs['h344][11] & csrs['h300][3];
    check({tag, ".csr_RD"}, bus.csr_RD, exp_rd);
    check({tag, ".illegal"}, bus.csr_illegal, !csrs.exists(a));
    check({tag, ".mtvec"}, bus.mtvec, csrs['h305]);
    check({tag, ".mepc"}, bus.mepc, csrs['h341]);
    check({tag, ".intr_req"}, bus.intr_req, exp_req);
  endtask

  // Called mid-cycle: check settled outputs, then advance one edge
  task automatic step(input string tag);
    #2;
    check_outputs(tag);
    @(posedge CLK);
    if (!RST) ref_update();
    #1;
  endtask

  task automatic drive(input logic [11:0] addr, input int op, input logic we, input logic [31:0] wd);
    bus.csr_ADDR = addr;
    bus.csr_op   = csr_op_e'(op[1:0]);
    bus.csr_WE   = we;
    bus.csr_WD   = wd;
  endtask

  task automatic peek(input logic [11:0] addr, input string tag, input logic [31:0] exp);
    drive(addr, 0, 1'b0, 32'h0);
    #1;
    check(tag, bus.csr_RD, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [11:0] addrs [8];
    wmask['h300] = 32'h0000_0088;
    wmask['h305] = 32'hFFFF_FFFC;
    wmask['h340] = 32'hFFFF_FFFF;
    wmask['h341] = 32'hFFFF_FFFC;
    wmask['h342] = 32'hFFFF_FFFF;
    wmask['h344] = 32'h0;
    addrs = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'h344, 12'h7C0, 12'h301};

    RST = 1'b1;
    ref_reset();
    drive(12'h300, 0, 1'b0, 32'h0);
    bus.PC = 32'h0; bus.int_taken = 1'b0; bus.mret_exec = 1'b0; bus.INTR = 1'b0;
    #3;
    check("rst.csr_RD", bus.csr_RD, 32'h0);
    check("rst.illegal", bus.csr_illegal, 1'b0);
    check("rst.mtvec", bus.mtvec, 32'h0);
    check("rst.mepc", bus.mepc, 32'h0);
    check("rst.intr_req", bus.intr_req, 1'b0);
    @(negedge CLK);
    RST = 1'b0;

    drive(12'h305, 1, 1'b1, 32'h0000_0103);
    step("mtvec_wr");
    peek(12'h305, "mtvec_rd", 32'h0000_0100);
    check("mtvec_out", bus.mtvec, 32'h0000_0100);

    drive(12'h300, 2, 1'b1, 32'h8);
    step("mstatus_rs");
    peek(12'h300, "mstatus_set", 32'h8);
    drive(12'h300, 3, 1'b1, 32'h8);
    step("mstatus_rc");
    peek(12'h300, "mstatus_clr", 32'h0);
    peek(12'h7C0, "unmapped_rd", 32'h0);
    check("unmapped_illegal", bus.csr_illegal, 1'b1);

    drive(12'h300, 2, 1'b1, 32'h8);
    step("mie_on");
    drive(12'h300, 0, 1'b0, 32'h0);
    bus.INTR = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step("intr_sync");
      check($sformatf("intr_lat%0d", i), bus.intr_req, (i == 3));
    end
    bus.int_taken = 1'b1;
    bus.PC = 32'h0000_0044;
    step("trap");
    bus.int_taken = 1'b0;
    #1;
    check("trap.mepc", bus.mepc, 32'h44);
    check("trap.intr_req", bus.intr_req, 1'b0);
    peek(12'h342, "trap.mcause", 32'h8000_000B);
    peek(12'h300, "trap.mstatus", 32'h80);

    bus.mret_exec = 1'b1;
    step("mret");
    bus.mret_exec = 1'b0;
    peek(12'h300, "mret.mstatus", 32'h88);
    for (int i = 0; i < 5; i++) begin
      step("intr_held");
      check("intr_held.req", bus.intr_req, 1'b0);
    end

    bus.INTR = 1'b0;
    for (int i = 0; i < 5; i++) step("intr_low");
    bus.INTR = 1'b1;
    for (int i = 0; i < 3; i++) step("intr_rise2");
    bus.int_taken = 1'b1;
    drive(12'h300, 1, 1'b1, 32'h8);
    step("trap_vs_wr");
    bus.int_taken = 1'b0;
    peek(12'h300, "trap_vs_wr.mstatus", 32'h80);
    peek(12'h344, "edge_vs_trap.mip", 32'h800);

    drive(12'h305, 1, 1'b1, 32'h0000_0207);
    #2;
    RST = 1'b1;
    ref_reset();
    #1;
    check("arst.csr_RD", bus.csr_RD, 32'h0);
    check("arst.mtvec", bus.mtvec, 32'h0);
    check("arst.mepc", bus.mepc, 32'h0);
    check("arst.intr_req", bus.intr_req, 1'b0);
    step("in_reset");
    RST = 1'b0;
    step("post_reset_wr");
    peek(12'h305, "post_reset.mtvec", 32'h0000_0204);

    for (int i = 0; i < 600; i++) begin
      drive(addrs[$urandom_range(0, 7)], int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom);
      bus.PC        = $urandom;
      bus.int_taken = ($urandom_range(0, 15) == 0);
      bus.mret_exec = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) bus.INTR = ~bus.INTR;
      if (i == 300) begin
        RST = 1'b1;
        ref_reset();
      end else if (i == 302) begin
        RST = 1'b0;
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
